// File: rtl/p2s_shift_driver_if.sv
// p2s_shift_driver_if: request/serial-pin bundle between GPIO control logic and the shift driver
// Signals:
//   start    - transfer request (master -> driver)
//   par_data - word to serialize (master -> driver)
//   s_clk    - serial shift clock to the chain
//   s_dout   - serial data to the chain
//   s_clrn   - active-low clear to the chain
//   s_pen    - latch/parallel-enable strobe to the chain
//   busy     - transfer in progress
//   done     - one-cycle completion pulse
interface p2s_shift_driver_if #(
  parameter int DATA_BITS = 16
);
  logic                 start;
  logic [DATA_BITS-1:0] par_data;
  logic                 s_clk;
  logic                 s_dout;
  logic                 s_clrn;
  logic                 s_pen;
  logic                 busy;
  logic                 done;
  modport master (
    output start, par_data,
    input  s_clk, s_dout, s_clrn, s_pen, busy, done
  );
  modport slave (
    input  start, par_data,
    output s_clk, s_dout, s_clrn, s_pen, busy, done
  );
endinterface

// File: rtl/p2s_shift_driver.sv
// p2s_shift_driver: serializes a parallel word into an external shift-register chain, then strobes its latch
// Ports:
//   clk - system clock, all state on posedge
//   rst - asynchronous active-high reset
//   bus - p2s_shift_driver_if.slave: start/par_data in; s_clk/s_dout/s_clrn/s_pen/busy/done out
// Parameters:
//   DATA_BITS - bits per transfer (>=2)
//   DIV       - serial clock half-period in clk cycles (>=1)
// Build option:
//   P2S_LSB_FIRST_EN - when defined, par_data[0] is shifted first; otherwise MSB first
module p2s_shift_driver #(
  parameter int DATA_BITS = 16,
  parameter int DIV       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  p2s_shift_driver_if.slave     bus
);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int PW = $clog2(DIV) + 1;
`ifdef P2S_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [PW-1:0]        ph_q, ph_d;
  logic                 s_clk_q, s_clk_d;
  logic                 s_dout_q, s_dout_d;
  logic                 s_clrn_q, s_clrn_d;
  logic                 s_pen_q, s_pen_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ph_end;
  assign ph_end = ph_q == PW'(DIV - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      bit_q    <= '0;
      ph_q     <= '0;
      s_clk_q  <= 1'b0;
      s_dout_q <= 1'b0;
      s_clrn_q <= 1'b0;
      s_pen_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      ph_q     <= ph_d;
      s_clk_q  <= s_clk_d;
      s_dout_q <= s_dout_d;
      s_clrn_q <= s_clrn_d;
      s_pen_q  <= s_pen_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  // The phase counter times both serial half-periods and the latch strobe.
  // s_dout only moves on the high->low edge of s_clk, so it is stable at every rise.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bit_d    = bit_q;
    ph_d     = ph_end ? '0 : ph_q + PW'(1);
    s_clk_d  = s_clk_q;
    s_dout_d = s_dout_q;
    s_clrn_d = 1'b1;
    s_pen_d  = s_pen_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ph_d     = '0;
        s_clk_d  = 1'b0;
        s_pen_d  = 1'b0;
        s_dout_d = 1'b0;
        busy_d   = 1'b0;
        if (bus.start) begin
          state_d  = SHIFT;
          sr_d     = bus.par_data;
          bit_d    = BW'(DATA_BITS);
          busy_d   = 1'b1;
          s_dout_d = LSB_FIRST ? bus.par_data[0] : bus.par_data[DATA_BITS-1];
        end
      end
      SHIFT: begin
        if (ph_end) begin
          s_clk_d = ~s_clk_q;
          if (s_clk_q) begin
            bit_d    = bit_q - BW'(1);
            sr_d     = LSB_FIRST ? sr_q >> 1 : sr_q << 1;
            s_dout_d = LSB_FIRST ? sr_q[1] : sr_q[DATA_BITS-2];
            if (bit_q == BW'(1)) begin
              state_d  = LATCH;
              s_dout_d = 1'b0;
              s_pen_d  = 1'b1;
            end
          end
        end
      end
      LATCH: begin
        if (ph_end) begin
          state_d = IDLE;
          s_pen_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.s_clk  = s_clk_q;
  assign bus.s_dout = s_dout_q;
  assign bus.s_clrn = s_clrn_q;
  assign bus.s_pen  = s_pen_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_p2s_shift_driver.sv
// tb_p2s_shift_driver: directed self-checking bench for p2s_shift_driver (DATA_BITS=16, DIV=2)
module tb_p2s_shift_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  p2s_shift_driver_if #(.DATA_BITS(16)) bus ();
  p2s_shift_driver #(.DATA_BITS(16), .DIV(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] seq(input logic [15:0] d);
`ifdef P2S_LSB_FIRST_EN
    for (int i = 0; i < 16; i++) seq[i] = d[15-i];
`else
    seq = d;
`endif
  endfunction
  function automatic logic [5:0] outs();
    return {bus.s_clk, bus.s_dout, bus.s_clrn, bus.s_pen, bus.busy, bus.done};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [15:0] d, input bit hold, input bit toggle,
                     input int poke_at, input logic [15:0] next_d);
    logic [15:0] cap = '0;
    logic prev = 1'b0;
    logic busy0 = 1'b0;
    int pulses = 0, pen_first = -1, pen_cnt = 0, done_at = -1;
    bus.par_data = d;
    bus.start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 100 && done_at < 0; n++) begin
      @(negedge clk);
      if (n == 0) busy0 = bus.busy;
      if (bus.s_clk && !prev) begin
        pulses++;
        cap = {cap[14:0], bus.s_dout};
      end
      prev = bus.s_clk;
      if (bus.s_pen) begin
        if (pen_first < 0) pen_first = n;
        pen_cnt++;
      end
      if (bus.done) begin
        done_at = n;
        bus.par_data = next_d;
      end else if (toggle) bus.par_data = ~bus.par_data;
      if (!hold) bus.start = (n == poke_at);
    end
    chk({tag, " busy0"}, 32'(busy0), 32'd1);
    chk({tag, " bits"}, 32'(cap), 32'(seq(d)));
    chk({tag, " pulses"}, pulses, 16);
    chk({tag, " pen_first"}, pen_first, 64);
    chk({tag, " pen_cnt"}, pen_cnt, 2);
    chk({tag, " done_at"}, done_at, 66);
  endtask
  initial begin
    int extra;
    bus.start = 1'b0;
    bus.par_data = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("reset outs", 32'(outs()), 32'h00);
    rst = 1'b0;
    #1 chk("clrn before edge", 32'(bus.s_clrn), 32'd0);
    @(negedge clk);
    chk("after release", 32'(outs()), 32'h08);
    @(negedge clk);
    run("a5c3", 16'hA5C3, 1'b0, 1'b0, -1, 16'h0000);
    @(negedge clk);
    chk("idle after a5c3", 32'(outs()), 32'h08);
    run("hold1", 16'hFFFF, 1'b1, 1'b1, -1, 16'h0000);
    run("hold2", 16'h0000, 1'b1, 1'b1, -1, 16'hFFFF);
    bus.start = 1'b0;
    @(negedge clk);
    chk("idle after hold", 32'(outs()), 32'h08);
    run("poke", 16'h5A3C, 1'b0, 1'b0, 20, 16'h0000);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.s_clk) extra++;
    end
    chk("poke no retrigger", extra, 0);
    bus.par_data = 16'h0F0F;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    chk("bit7 s_clk high", 32'(bus.s_clk), 32'd1);
    chk("bit7 busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1 chk("abort outs", 32'(outs()), 32'h00);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (outs() != 6'h00) extra++;
    end
    chk("held reset quiet", extra, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("after abort release", 32'(outs()), 32'h08);
    run("post", 16'h3C5A, 1'b0, 1'b0, -1, 16'h0000);
    @(negedge clk);
    chk("final idle", 32'(outs()), 32'h08);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
